reg_write_arbiter: RTL and testbench

Round-robin write arbiter and sequencer for the shared 8-bit holding register. Up to N_REQ requesters each present a write request with data. The block grants one request at a time, loads the register, and returns a one-cycle acknowledge to the winner. A synchronous clear command overrides all requesters. It sits in front of the register and owns its only write port.

---
 rtl/reg_write_arbiter.sv | 127 ++++++++++++
 tb/tb_reg_write_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter that owns the single write port of a shared holding register.
// Grants one requester per three-cycle IDLE -> WRITE -> ACK sequence; a software clear overrides requests.
module reg_write_arbiter #(
    parameter int N_REQ = 4,
    parameter int DW    = 8,
    parameter int OW    = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] data,
    input  logic                sw_clr,
    output logic [N_REQ-1:0]    ack,
    output logic [DW-1:0]       reg_out,
    output logic [OW-1:0]       owner,
    output logic                busy,
    output logic                lsb_n
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [DW-1:0]      reg_q, reg_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [OW-1:0]      last_q, last_d;
    logic               clr_pend_q, clr_pend_d;
    logic               busy_q, busy_d;
    logic [DW-1:0]      sel_data;
    logic [OW-1:0]      rr_win;

    // Search starts just after the previous winner and wraps modulo N_REQ.
    function automatic logic [OW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [OW-1:0]    last);
        logic [OW-1:0] win;
        logic [OW-1:0] idx;
        logic          found;
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = OW'((int'(last) + k) % N_REQ);
            if (!found && r[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    always_comb begin
        sel_data = data[0 +: DW];
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == OW'(i)) sel_data = data[i*DW +: DW];
        end
    end

    assign rr_win = rr_pick(req, last_q);

    always_comb begin
        state_d    = state_q;
        reg_d      = reg_q;
        ack_d      = '0;
        owner_d    = owner_q;
        last_d     = last_q;
        clr_pend_d = clr_pend_q;
        case (state_q)
            IDLE: begin
                if (sw_clr) begin
                    clr_pend_d = 1'b1;
                    state_d    = WRITE;
                end else if (req != '0) begin
                    owner_d = rr_win;
                    last_d  = rr_win;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (clr_pend_q) begin
                    reg_d      = '0;
                    clr_pend_d = 1'b0;
                end else begin
                    reg_d = sel_data;
                    ack_d = N_REQ'(1) << owner_q;
                end
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= IDLE;
            reg_q      <= '0;
            ack_q      <= '0;
            owner_q    <= '0;
            last_q     <= OW'(N_REQ - 1);
            clr_pend_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            reg_q      <= reg_d;
            ack_q      <= ack_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            clr_pend_q <= clr_pend_d;
            busy_q     <= busy_d;
        end
    end

    assign ack     = ack_q;
    assign reg_out = reg_q;
    assign owner   = owner_q;
    assign busy    = busy_q;
    assign lsb_n   = ~reg_q[0];

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: reset, single write, round robin, clear priority, reset mid-op.
// Inputs change #1 after a rising edge; outputs are sampled at that same point.
module tb_reg_write_arbiter;

    localparam int N_REQ = 4;
    localparam int DW    = 8;
    localparam int OW    = 2;

    logic                clk;
    logic                clr;
    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] data;
    logic                sw_clr;
    logic [N_REQ-1:0]    ack;
    logic [DW-1:0]       reg_out;
    logic [OW-1:0]       owner;
    logic                busy;
    logic                lsb_n;

    int checks;
    int failures;

    reg_write_arbiter #(.N_REQ(N_REQ), .DW(DW)) dut (
        .clk     (clk),
        .clr     (clr),
        .req     (req),
        .data    (data),
        .sw_clr  (sw_clr),
        .ack     (ack),
        .reg_out (reg_out),
        .owner   (owner),
        .busy    (busy),
        .lsb_n   (lsb_n)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] v);
        data[i*DW +: DW] = v;
    endtask

    // ack must never have more than one bit set
    always @(negedge clk) begin
        if (!clr) check("ack_onehot0", 32'($onehot0(ack)), 32'd1);
    end

    initial begin
        checks   = 0;
        failures = 0;
        clr      = 1'b1;
        sw_clr   = 1'b0;
        req      = 4'($urandom_range(0, 15));
        data     = $urandom;

        // Reset holds outputs regardless of inputs
        repeat (3) begin
            step();
            req  = 4'($urandom_range(0, 15));
            data = $urandom;
        end
        check("rst_reg", 32'(reg_out), 32'h00);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_owner", 32'(owner), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_lsb_n", 32'(lsb_n), 32'h1);
        clr  = 1'b0;
        req  = '0;
        data = '0;
        step();
        step();
        check("idle_reg", 32'(reg_out), 32'h00);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_owner", 32'(owner), 32'h0);

        // Single write from requester 0
        set_data(0, 8'hA5);
        req = 4'b0001;
        step();                                  // E0
        check("sw_owner_e0", 32'(owner), 32'h0);
        check("sw_busy_e0", 32'(busy), 32'h1);
        check("sw_ack_e0", 32'(ack), 32'h0);
        step();                                  // E1
        check("sw_reg_e1", 32'(reg_out), 32'hA5);
        check("sw_ack_e1", 32'(ack), 32'b0001);
        check("sw_busy_e1", 32'(busy), 32'h1);
        check("sw_lsb_n", 32'(lsb_n), 32'h0);
        req = 4'b0000;
        step();                                  // E2
        check("sw_ack_e2", 32'(ack), 32'h0);
        check("sw_busy_e2", 32'(busy), 32'h0);
        step();
        check("sw_hold_reg", 32'(reg_out), 32'hA5);

        // Round robin: re-reset so the pointer starts at N_REQ-1
        clr = 1'b1;
        #2;
        clr = 1'b0;
        step();
        for (int i = 0; i < N_REQ; i++) set_data(i, 8'(8'h10 + i));
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            int exp_w;
            exp_w = t % N_REQ;
            step();                              // E0
            check("rr_owner", 32'(owner), 32'(exp_w));
            check("rr_ack_e0", 32'(ack), 32'h0);
            step();                              // E1
            check("rr_ack", 32'(ack), 32'(1 << exp_w));
            check("rr_reg", 32'(reg_out), 32'(8'h10 + exp_w));
            req[exp_w] = 1'b0;                   // dropped during ACK, ignored
            step();                              // E2
            check("rr_ack_low", 32'(ack), 32'h0);
            check("rr_busy_low", 32'(busy), 32'h0);
            req[exp_w] = 1'b1;
        end
        req = '0;
        step();
        step();

        // Load 0x3C via requester 1 (pointer now 0, so 1 is next anyway)
        set_data(1, 8'h3C);
        req = 4'b0010;
        step();
        check("ld_owner", 32'(owner), 32'h1);
        step();
        check("ld_reg", 32'(reg_out), 32'h3C);
        req = '0;
        step();

        // Clear wins over simultaneous request
        set_data(2, 8'h82);
        sw_clr = 1'b1;
        req    = 4'b0100;
        step();                                  // E0
        check("clr_owner_e0", 32'(owner), 32'h1);
        check("clr_busy_e0", 32'(busy), 32'h1);
        sw_clr = 1'b0;
        step();                                  // E1
        check("clr_reg_e1", 32'(reg_out), 32'h00);
        check("clr_ack_e1", 32'(ack), 32'h0);
        check("clr_lsb_n", 32'(lsb_n), 32'h1);
        step();                                  // E2
        check("clr_ack_e2", 32'(ack), 32'h0);
        check("clr_busy_e2", 32'(busy), 32'h0);
        step();                                  // E3
        check("clr_owner_e3", 32'(owner), 32'h2);
        step();                                  // E4
        check("clr_reg_e4", 32'(reg_out), 32'h82);
        check("clr_ack_e4", 32'(ack), 32'b0100);
        req = '0;
        step();                                  // E5
        check("clr_ack_e5", 32'(ack), 32'h0);

        // Reset between E0 and E1 aborts the write
        set_data(1, 8'h5B);
        req = 4'b0010;
        step();                                  // E0
        check("mid_owner_e0", 32'(owner), 32'h1);
        #2;
        clr = 1'b1;
        #1;
        check("mid_reg_rst", 32'(reg_out), 32'h00);
        check("mid_busy_rst", 32'(busy), 32'h0);
        check("mid_owner_rst", 32'(owner), 32'h0);
        step();                                  // E1 edge under reset
        check("mid_ack_e1", 32'(ack), 32'h0);
        check("mid_reg_e1", 32'(reg_out), 32'h00);
        clr = 1'b0;
        req = 4'b1001;
        step();
        check("mid_owner_next", 32'(owner), 32'h0);
        step();
        check("mid_ack_next", 32'(ack), 32'b0001);
        req = '0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
